// File: rtl/clk_switch_seq_pkg.sv
// Shared definitions for clock controllers: sequencer state encoding and clk_sel values.
package clk_switch_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GOFF   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SLEEP  = 2'd3
    } state_t;

    localparam logic SEL_CLK_A = 1'b0;
    localparam logic SEL_CLK_B = 1'b1;

    function automatic int unsigned wait_cnt_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_ctrl_dncnt.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module clk_ctrl_dncnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_switch_seq.sv
// Glitch-safe clock source switch sequencer for a clk_mux2 + gated_clk_cell pair.
// Idle auto-gating (SLEEP state) is built only when CLK_SW_AUTO_GATE_EN is defined.
module clk_switch_seq
    import clk_switch_seq_pkg::*;
#(
    parameter int unsigned OFF_WAIT    = 4,
    parameter int unsigned SETTLE_WAIT = 8,
    parameter int unsigned IDLE_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_req,
    input  logic              sw_target,
    input  logic              pad_yy_test_mode,
    input  logic              module_busy,
    input  logic              auto_gate_en,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              clk_sel,
    output logic              gate_en,
    output logic              sw_busy,
    output logic              sw_ack,
    output logic              clk_sleep
);

    localparam int unsigned CW = wait_cnt_w(OFF_WAIT, SETTLE_WAIT);

    state_t          state, state_d;
    logic            target, target_d;
    logic            clk_sel_d, gate_en_d, sw_busy_d, sw_ack_d;
    logic            accept;
    logic            sleep_go, wake;
    logic            cnt_load, cnt_zero;
    logic [CW-1:0]   cnt_val;

    clk_ctrl_dncnt #(.W(CW)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef CLK_SW_AUTO_GATE_EN
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_RUN || module_busy) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign sleep_go = auto_gate_en && !pad_yy_test_mode && (idle_thresh != '0) &&
                      (idle_cnt == idle_thresh);
    assign wake     = module_busy || pad_yy_test_mode;
`else
    logic unused_auto_gate;
    assign unused_auto_gate = ^{module_busy, auto_gate_en, idle_thresh};
    assign sleep_go = 1'b0;
    assign wake     = 1'b1;
`endif

    always_comb begin
        state_d   = state;
        target_d  = target;
        clk_sel_d = clk_sel;
        sw_ack_d  = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        accept    = sw_req && (state == ST_RUN || state == ST_SLEEP);

        case (state)
            ST_RUN, ST_SLEEP: begin
                if (accept && sw_target != clk_sel) begin
                    state_d  = ST_GOFF;
                    target_d = sw_target;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(OFF_WAIT - 1);
                end else begin
                    // A same-source request is acked at once and blocks idle gating this cycle
                    sw_ack_d = accept;
                    if (state == ST_RUN && !accept && sleep_go) state_d = ST_SLEEP;
                    if (state == ST_SLEEP && wake)              state_d = ST_RUN;
                end
            end
            ST_GOFF: begin
                if (cnt_zero) begin
                    state_d   = ST_SETTLE;
                    clk_sel_d = target ? SEL_CLK_B : SEL_CLK_A;
                    cnt_load  = 1'b1;
                    cnt_val   = CW'(SETTLE_WAIT - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d  = ST_RUN;
                    sw_ack_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        gate_en_d = (state_d == ST_RUN) || pad_yy_test_mode;
        sw_busy_d = (state_d == ST_GOFF) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            target  <= SEL_CLK_A;
            clk_sel <= SEL_CLK_A;
            gate_en <= 1'b1;
            sw_busy <= 1'b0;
            sw_ack  <= 1'b0;
        end else begin
            state   <= state_d;
            target  <= target_d;
            clk_sel <= clk_sel_d;
            gate_en <= gate_en_d;
            sw_busy <= sw_busy_d;
            sw_ack  <= sw_ack_d;
        end
    end

`ifdef CLK_SW_AUTO_GATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk_sleep <= 1'b0;
        else     clk_sleep <= (state_d == ST_SLEEP);
    end
`else
    assign clk_sleep = 1'b0;
`endif

endmodule
